// File: rtl/key_press_ctrl.sv
// ============================================================================
// Module   : key_press_ctrl
// Brief    : Push-button classifier. Synchronizes and debounces a raw key,
//            then emits one-cycle pulses for short presses and long presses.
//            Optional auto-repeat while long-held: define KEY_AUTO_REPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_press_ctrl #(
    parameter int DEBOUNCE_CYC = 200,
    parameter int LONG_CYC     = 10000,
    parameter int REPEAT_CYC   = 2000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic key_in,
    output logic inc_short,
    output logic inc_long,
    output logic key_pressed
);

    // All parameters must lie in 1..16383 to fit the shared 14-bit counter.
    localparam logic [13:0] c_DEB_LAST  = 14'(DEBOUNCE_CYC - 1);
    localparam logic [13:0] c_LONG_LAST = 14'(LONG_CYC - 1);
    localparam logic [13:0] c_REP_LAST  = 14'(REPEAT_CYC - 1);

`ifdef KEY_AUTO_REPEAT_EN
    localparam bit c_AUTO_REPEAT = 1'b1;
`else
    localparam bit c_AUTO_REPEAT = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_DEB_PRESS   = 3'd1,
        S_PRESSED     = 3'd2,
        S_LONG_HELD   = 3'd3,
        S_DEB_RELEASE = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_sync1;
    logic        r_key_sync;
    logic [13:0] r_cnt;
    logic [13:0] w_cnt_nxt;
    logic [13:0] w_cnt_inc;
    logic        r_short_flag;
    logic        w_short_flag_nxt;
    logic        r_inc_short;
    logic        w_inc_short_nxt;
    logic        r_inc_long;
    logic        w_inc_long_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1      <= 1'b0;
            r_key_sync   <= 1'b0;
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_short_flag <= 1'b0;
            r_inc_short  <= 1'b0;
            r_inc_long   <= 1'b0;
        end else begin
            r_sync1      <= key_in;
            r_key_sync   <= r_sync1;
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_short_flag <= w_short_flag_nxt;
            r_inc_short  <= w_inc_short_nxt;
            r_inc_long   <= w_inc_long_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_cnt_inc        = r_cnt + 14'd1;
        w_short_flag_nxt = r_short_flag;
        w_inc_short_nxt  = 1'b0;
        w_inc_long_nxt   = 1'b0;

        if (!enable) begin
            w_state_nxt      = S_IDLE;
            w_cnt_nxt        = '0;
            w_short_flag_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_key_sync) begin
                        w_state_nxt = S_DEB_PRESS;
                        w_cnt_nxt   = '0;
                    end
                end

                S_DEB_PRESS: begin
                    if (!r_key_sync) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_DEB_LAST) begin
                        w_state_nxt = S_PRESSED;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end

                // Release is checked first so it wins over a coincident long timeout.
                S_PRESSED: begin
                    if (!r_key_sync) begin
                        w_state_nxt      = S_DEB_RELEASE;
                        w_short_flag_nxt = 1'b1;
                        w_cnt_nxt        = '0;
                    end else if (r_cnt == c_LONG_LAST) begin
                        w_state_nxt    = S_LONG_HELD;
                        w_cnt_nxt      = '0;
                        w_inc_long_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end

                // Gating on r_inc_long keeps pulses apart even when REPEAT_CYC is 1.
                S_LONG_HELD: begin
                    if (!r_key_sync) begin
                        w_state_nxt      = S_DEB_RELEASE;
                        w_short_flag_nxt = 1'b0;
                        w_cnt_nxt        = '0;
                    end else if (c_AUTO_REPEAT) begin
                        if (r_cnt == c_REP_LAST) begin
                            w_cnt_nxt      = '0;
                            w_inc_long_nxt = !r_inc_long;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end else begin
                        w_cnt_nxt = '0;
                    end
                end

                S_DEB_RELEASE: begin
                    if (r_key_sync) begin
                        w_cnt_nxt = '0;
                    end else if (r_cnt == c_DEB_LAST) begin
                        w_state_nxt      = S_IDLE;
                        w_cnt_nxt        = '0;
                        w_inc_short_nxt  = r_short_flag;
                        w_short_flag_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end

                default: begin
                    w_state_nxt      = S_IDLE;
                    w_cnt_nxt        = '0;
                    w_short_flag_nxt = 1'b0;
                end
            endcase
        end
    end

    assign inc_short   = r_inc_short;
    assign inc_long    = r_inc_long;
    assign key_pressed = (r_state == S_PRESSED) || (r_state == S_LONG_HELD);

endmodule

`default_nettype wire

// File: tb/tb_key_press_ctrl.sv
// ============================================================================
// Module   : tb_key_press_ctrl
// Brief    : Self-checking bench for key_press_ctrl (DEB=4, LONG=20, REP=5).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_press_ctrl;

    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int REP  = 5;
`ifdef KEY_AUTO_REPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b1;
    logic key_in = 1'b0;
    logic inc_short;
    logic inc_long;
    logic key_pressed;

    key_press_ctrl #(
        .DEBOUNCE_CYC(DEB),
        .LONG_CYC    (LONG),
        .REPEAT_CYC  (REP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .key_in     (key_in),
        .inc_short  (inc_short),
        .inc_long   (inc_long),
        .key_pressed(key_pressed)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Behavioural reference: a delay line for the synchronizer, then the key
    // described by run lengths of the sampled level and time held since acceptance.
    bit m_s1, m_s2;
    int m_mode;     // 0 released, 1 down (debounced), 2 release pending
    int m_ones;     // consecutive high samples while released
    int m_hold;     // edges since press acceptance
    int m_zleft;    // low samples still needed to accept release
    bit m_long_seen, m_short_ok;
    bit m_inc_s, m_inc_l;

    function automatic void model_reset();
        m_s1 = 0; m_s2 = 0; m_mode = 0; m_ones = 0; m_hold = 0; m_zleft = 0;
        m_long_seen = 0; m_short_ok = 0; m_inc_s = 0; m_inc_l = 0;
    endfunction

    function automatic void model_edge();
        bit s;
        s = m_s2;
        m_inc_s = 0;
        m_inc_l = 0;
        m_s2 = m_s1;
        m_s1 = key_in;
        if (!rst_n) begin
            model_reset();
        end else if (!enable) begin
            m_mode = 0;
            m_ones = 0;
        end else begin
            case (m_mode)
                0: begin
                    if (s) begin
                        m_ones++;
                        if (m_ones == DEB + 1) begin
                            m_mode = 1; m_hold = 0; m_long_seen = 0;
                        end
                    end else begin
                        m_ones = 0;
                    end
                end
                1: begin
                    if (!s) begin
                        m_mode = 2; m_zleft = DEB; m_short_ok = !m_long_seen;
                    end else begin
                        m_hold++;
                        if (m_hold == LONG) begin
                            m_inc_l = 1; m_long_seen = 1;
                        end else if (AUTO && m_hold > LONG && (m_hold - LONG) % REP == 0) begin
                            m_inc_l = 1;
                        end
                    end
                end
                default: begin
                    if (s) begin
                        m_zleft = DEB;
                    end else begin
                        m_zleft--;
                        if (m_zleft == 0) begin
                            m_mode = 0; m_ones = 0; m_inc_s = m_short_ok;
                        end
                    end
                end
            endcase
        end
    endfunction

    // Pulse/level monitor used by the directed scenarios.
    int n_s, n_l, f_s, f_l, f_kp;

    task automatic clear_mon();
        n_s = 0; n_l = 0; f_s = -1; f_l = -1; f_kp = -1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check("inc_short", int'(inc_short), int'(m_inc_s));
        check("inc_long", int'(inc_long), int'(m_inc_l));
        check("key_pressed", int'(key_pressed), int'(m_mode == 1));
        if (inc_short) begin n_s++; if (f_s < 0) f_s = cyc; end
        if (inc_long)  begin n_l++; if (f_l < 0) f_l = cyc; end
        if (key_pressed && f_kp < 0) f_kp = cyc;
    endtask

    function automatic int off(input int f, input int t0);
        return (f < 0) ? -1 : f - t0;
    endfunction

    typedef struct {
        int hi;
        int n_short;
        int short_off;
        int n_long;
        int long_off;
        int kp_off;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int t0;
        model_reset();
        clear_mon();

        vecs[0] = '{3,  0, -1, 0, -1, -1};
        vecs[1] = '{4,  0, -1, 0, -1, -1};
        vecs[2] = '{5,  1, 11, 0, -1,  6};
        vecs[3] = '{10, 1, 16, 0, -1,  6};
        vecs[4] = '{24, 1, 30, 0, -1,  6};
        vecs[5] = '{25, 0, -1, 1, 26,  6};
        vecs[6] = '{40, 0, -1, AUTO ? 4 : 1, 26, 6};

        // Reset state
        #3;
        check("reset_inc_short", int'(inc_short), 0);
        check("reset_inc_long", int'(inc_long), 0);
        check("reset_key_pressed", int'(key_pressed), 0);
        repeat (2) step();
        #2 rst_n = 1'b1;
        repeat (5) step();

        // Table-driven press lengths
        for (int v = 0; v < 7; v++) begin
            clear_mon();
            key_in = 1'b1;
            t0 = cyc + 1;
            repeat (vecs[v].hi) step();
            key_in = 1'b0;
            repeat (45) step();
            check($sformatf("v%0d_n_short", v), n_s, vecs[v].n_short);
            check($sformatf("v%0d_short_off", v), off(f_s, t0), vecs[v].short_off);
            check($sformatf("v%0d_n_long", v), n_l, vecs[v].n_long);
            check($sformatf("v%0d_long_off", v), off(f_l, t0), vecs[v].long_off);
            check($sformatf("v%0d_kp_off", v), off(f_kp, t0), vecs[v].kp_off);
        end

        // Bouncing release: 0-1-0-1 then stable low
        clear_mon();
        key_in = 1'b1;
        t0 = cyc + 1;
        repeat (10) step();
        key_in = 1'b0; step();
        key_in = 1'b1; step();
        key_in = 1'b0; step();
        key_in = 1'b1; step();
        key_in = 1'b0;
        repeat (25) step();
        check("bounce_n_short", n_s, 1);
        check("bounce_short_off", off(f_s, t0), 19);
        check("bounce_n_long", n_l, 0);

        // Enable dropped mid-PRESSED, key released while disabled
        clear_mon();
        key_in = 1'b1;
        repeat (15) step();
        enable = 1'b0;
        step();
        check("en_drop_kp", int'(key_pressed), 0);
        key_in = 1'b0;
        repeat (10) step();
        enable = 1'b1;
        repeat (20) step();
        check("en_drop_n_short", n_s, 0);
        check("en_drop_n_long", n_l, 0);

        // Key held across enable rise is a new press
        key_in = 1'b1;
        repeat (12) step();
        enable = 1'b0;
        repeat (3) step();
        clear_mon();
        enable = 1'b1;
        t0 = cyc + 1;
        repeat (10) step();
        check("en_rise_kp_off", off(f_kp, t0), DEB);
        key_in = 1'b0;
        repeat (20) step();
        check("en_rise_n_short", n_s, 1);

        // Reset mid-PRESSED: immediate clear, then restart latency with key held
        key_in = 1'b1;
        repeat (12) step();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_pressed_kp", int'(key_pressed), 0);
        repeat (2) step();
        #2 rst_n = 1'b1;
        clear_mon();
        t0 = cyc + 1;
        repeat (10) step();
        check("rst_release_kp_off", off(f_kp, t0), 2 + DEB);

        // Reset mid-DEB_RELEASE: no pulse afterwards
        key_in = 1'b0;
        repeat (4) step();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_rel_inc_short", int'(inc_short), 0);
        check("rst_rel_kp", int'(key_pressed), 0);
        repeat (2) step();
        #2 rst_n = 1'b1;
        clear_mon();
        repeat (20) step();
        check("rst_rel_n_short", n_s, 0);

        // Randomized runs against the reference model
        for (int r = 0; r < 120; r++) begin
            int len;
            if ($urandom_range(0, 9) == 0) begin
                enable = 1'b0;
                repeat ($urandom_range(1, 8)) step();
                enable = 1'b1;
            end
            key_in = ~key_in;
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                              : int'($urandom_range(1, 45));
            repeat (len) step();
        end
        key_in = 1'b0;
        repeat (50) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/key_press_ctrl.md
KEY_PRESS_CTRL -- requirements
Module: key_press_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYC, default 200, consecutive stable cycles required to accept a level change (20 ms at 10 kHz).
REQ-002 SHALL have parameter LONG_CYC, default 10000, held cycles after debounce before a long press is declared (1 s).
REQ-003 SHALL have parameter REPEAT_CYC, default 2000, auto-repeat period while long-held (200 ms).
REQ-004 clk  input  1  single clock, 10 kHz nominal, rising-edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  high = classifier active; low = forced idle.
REQ-007 key_in  input  1  raw asynchronous push-button level, high = pressed.
REQ-008 inc_short  output  1  one-cycle pulse: short press completed; drives the time counter's inc_short.
REQ-009 inc_long  output  1  one-cycle pulse: long press declared, and each auto-repeat.
REQ-010 key_pressed  output  1  high while debounced key is held (PRESSED or LONG_HELD).

Function
REQ-011 key_in SHALL pass through a 2-flop synchronizer (key_sync); all decisions use key_sync only.
REQ-012 One 14-bit cycle counter cnt SHALL be shared by all states; every parameter SHALL be 1..16383.
REQ-013 States: IDLE, DEB_PRESS, PRESSED, LONG_HELD, DEB_RELEASE.
REQ-014 IDLE: key_sync=1 -> DEB_PRESS, cnt=0.
REQ-015 DEB_PRESS: key_sync=0 -> IDLE without a pulse; else cnt++; at cnt==DEBOUNCE_CYC-1 -> PRESSED, cnt=0.
REQ-016 PRESSED: cnt++; key_sync=0 -> DEB_RELEASE, short_flag=1, cnt=0; at cnt==LONG_CYC-1 -> LONG_HELD, cnt=0, inc_long=1 for that cycle.
REQ-017 If key_sync=0 and cnt==LONG_CYC-1 in the same PRESSED cycle, release SHALL win: no inc_long, short_flag=1.
REQ-018 LONG_HELD: key_sync=0 -> DEB_RELEASE, short_flag=0, cnt=0; otherwise behaviour per REQ-027/028.
REQ-019 DEB_RELEASE: key_sync=1 -> cnt=0, stay (bounce); else cnt++; at cnt==DEBOUNCE_CYC-1 -> IDLE, inc_short=short_flag for that cycle.
REQ-020 A long press SHALL never produce inc_short; a short press SHALL produce exactly one inc_short.
REQ-021 inc_short and inc_long SHALL be registered, never high together, never high two consecutive cycles.
REQ-022 enable=0 SHALL force IDLE, cnt=0, short_flag=0, pulses 0 on the next edge; in-progress press is discarded, no pulse.
REQ-023 Key held when enable rises SHALL be treated as a new press (IDLE -> DEB_PRESS).
REQ-024 Latency key_in edge -> key_pressed rise: 2 sync + DEBOUNCE_CYC cycles.

Reset
REQ-025 reset low SHALL asynchronously clear synchronizer flops, cnt, short_flag, state=IDLE, inc_short=0, inc_long=0, key_pressed=0.
REQ-026 Reset release SHALL be taken synchronously; first state change no earlier than the 3rd rising edge after release.

Configuration
REQ-027 With macro KEY_AUTO_REPEAT_EN defined: in LONG_HELD cnt++; at cnt==REPEAT_CYC-1 inc_long=1 for that cycle and cnt=0, repeating while held.
REQ-028 Without KEY_AUTO_REPEAT_EN: LONG_HELD SHALL hold cnt at 0 and emit no further pulses; exactly one inc_long per long press.

Verification (DEBOUNCE_CYC=4, LONG_CYC=20, REPEAT_CYC=5)
REQ-029 key_in high 10 cycles then low -> exactly one inc_short, 4 cycles after release sync; inc_long never.
REQ-030 key_in high 3 cycles, low -> no pulse, key_pressed stays 0 (glitch rejected).
REQ-031 key_in high 40 cycles, macro off -> one inc_long 2+4+20 cycles after press edge; no inc_short on release.
REQ-032 Same 40-cycle hold, KEY_AUTO_REPEAT_EN on -> inc_long at offset 26 and every 5 cycles after until release (4 pulses total).
REQ-033 Short press, release bouncing 1-0-1-0 within 3 cycles -> single inc_short after 4 stable low cycles.
REQ-034 enable dropped mid-PRESSED, or reset asserted mid-DEB_RELEASE -> outputs 0 immediately (reset) / next edge (enable), no pulse emitted.
